md_sched: RTL and testbench

MD_SCHED -- requirements
Module: md_sched

---
 rtl/md_sched.sv | 140 ++++++++++++++
 tb/tb_md_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Multiply/divide scheduler: times MULT/DIV operations with a two-state FSM and a down-counter,
// owns the architectural HI/LO registers and raises a decode-stage stall while HI/LO is in flight.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        id_md,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_pend_hi;
  logic [31:0]       r_pend_lo;
  logic              r_div0;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;

  logic              w_start;
  logic              w_rt_zero;
  logic              w_sdiv_ovf;
  logic [31:0]       w_sdvs;
  logic [31:0]       w_udvs;
  logic signed [63:0] w_smul;
  logic [63:0]       w_umul;
  logic signed [31:0] w_sq;
  logic signed [31:0] w_sr;
  logic [31:0]       w_uq;
  logic [31:0]       w_ur;
  logic [31:0]       w_res_hi;
  logic [31:0]       w_res_lo;

  // Gated with reset so start/stall_req read 0 the moment reset is asserted.
  assign w_start   = reset & op_valid & (op <= OP_DIVU) & (r_state == S_IDLE);
  assign start     = w_start;
  assign busy      = (r_state == S_RUN);
  assign stall_req = id_md & (w_start | busy);
  assign hi        = r_hi;
  assign lo        = r_lo;

  assign w_smul = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign w_umul = {32'd0, rs} * {32'd0, rt};

  // Divide-by-zero and MIN_INT/-1 both divide by 1 instead: the former is never committed,
  // the latter yields exactly the wrapped quotient 0x80000000 with remainder 0.
  assign w_rt_zero  = (rt == 32'd0);
  assign w_sdiv_ovf = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
  assign w_sdvs     = (w_rt_zero || w_sdiv_ovf) ? 32'd1 : rt;
  assign w_udvs     = w_rt_zero ? 32'd1 : rt;

  assign w_sq = $signed(rs) / $signed(w_sdvs);
  assign w_sr = $signed(rs) % $signed(w_sdvs);
  assign w_uq = rs / w_udvs;
  assign w_ur = rs % w_udvs;

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    unique case (op)
      OP_MULT:  begin w_res_hi = w_smul[63:32];   w_res_lo = w_smul[31:0];   end
      OP_MULTU: begin w_res_hi = w_umul[63:32];   w_res_lo = w_umul[31:0];   end
      OP_DIV:   begin w_res_hi = 32'(w_sr);       w_res_lo = 32'(w_sq);      end
      OP_DIVU:  begin w_res_hi = w_ur;            w_res_lo = w_uq;           end
      default:  ;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_div0    <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state   <= S_RUN;
            r_cnt     <= op[1] ? DIV_LOAD : MULT_LOAD;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_div0    <= op[1] & w_rt_zero;
          end else if (op_valid && op == OP_MTHI) begin
            r_hi <= rs;
          end else if (op_valid && op == OP_MTLO) begin
            r_lo <= rs;
          end
        end
        S_RUN: begin
          // New operations are ignored here; upstream stalls keep them from arriving.
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            if (!r_div0) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed vector table, hand-written stall/reset sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        id_md;
  logic        start;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .id_md     (id_md),
    .start     (start),
    .busy      (busy),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        id;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural effect of one operation, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output int n);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    n  = 0;
    case (o)
      3'd0: begin t = sa * sb; h = t[63:32]; l = t[31:0]; n = MULT_N; end
      3'd1: begin t = ua * ub; h = t[63:32]; l = t[31:0]; n = MULT_N; end
      3'd2: begin
        n = DIV_N;
        if (b != 0) begin t = sa / sb; l = t[31:0]; t = sa % sb; h = t[31:0]; end
      end
      3'd3: begin
        n = DIV_N;
        if (b != 0) begin t = ua / ub; l = t[31:0]; t = ua % ub; h = t[31:0]; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask

  // One operation: drive it for one cycle, then count busy cycles and check the committed result.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic id, input logic [31:0] eh, input logic [31:0] el, input int en);
    int nb;
    bit stall_ok;
    @(negedge clk);
    op_valid = 1'b1; op = o; rs = a; rt = b; id_md = id;
    #1;
    check("start", 64'(start), 64'(o <= 3'd3));
    check("stall_start", 64'(stall_req), 64'(id && (o <= 3'd3)));
    @(negedge clk);
    op_valid = 1'b0;
    nb = 0;
    stall_ok = 1'b1;
    while (busy && nb < 100) begin
      nb++;
      if (stall_req !== id) stall_ok = 1'b0;
      @(negedge clk);
    end
    check("busy_len", 64'(nb), 64'(en));
    check("stall_busy", 64'(stall_ok), 64'd1);
    check("stall_after", 64'(stall_req), 64'd0);
    check("hi", 64'(hi), 64'(eh));
    check("lo", 64'(lo), 64'(el));
    id_md = 1'b0;
  endtask

  vec_t        vecs[10];
  logic [31:0] ref_hi, ref_lo;
  int          ref_n;
  int          nb;
  bit          ok;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_N};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, MULT_N};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    vecs[3] = '{3'd4, 32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5678, 32'hFFFF_FFFD, 0};
    vecs[4] = '{3'd3, 32'h0000_0005, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'hFFFF_FFFD, DIV_N};
    vecs[5] = '{3'd5, 32'hCAFE_F00D, 32'h0000_0001, 1'b0, 32'h1234_5678, 32'hCAFE_F00D, 0};
    vecs[6] = '{3'd3, 32'd100,       32'd7,         1'b1, 32'h0000_0002, 32'h0000_000E, DIV_N};
    vecs[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, DIV_N};
    vecs[8] = '{3'd6, 32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD, 0};
    vecs[9] = '{3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_000C, MULT_N};

    // Reset held with a valid MULT offered: nothing may start or stall.
    reset = 1'b0; op_valid = 1'b1; op = 3'd0; rs = 32'd3; rt = 32'd4; id_md = 1'b1;
    #2;
    check("rst_start", 64'(start), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b0; id_md = 1'b0;

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].id, vecs[i].exp_hi, vecs[i].exp_lo,
            vecs[i].exp_busy);

    // Second MULT offered during busy cycle 2 must be ignored.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd0; rs = 32'd3; rt = 32'd5; id_md = 1'b1;
    #1;
    check("seq_start", 64'(start), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    op_valid = 1'b1; rs = 32'd7; rt = 32'd9;
    #1;
    check("seq_ignored_start", 64'(start), 64'd0);
    check("seq_stall_busy", 64'(stall_req), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
    nb = 2;
    while (busy && nb < 100) begin nb++; @(negedge clk); end
    check("seq_busy_len", 64'(nb), 64'(MULT_N));
    check("seq_stall_after", 64'(stall_req), 64'd0);
    check("seq_hi", 64'(hi), 64'd0);
    check("seq_lo", 64'(lo), 64'd15);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || lo !== 32'd15) ok = 1'b0;
    end
    check("seq_no_second", 64'(ok), 64'd1);
    id_md = 1'b0;

    // Reset during busy cycle 3 of a DIV aborts it; the result is never committed.
    @(negedge clk);
    op_valid = 1'b1; op = 3'd2; rs = 32'd100; rt = 32'd3; id_md = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b0; op_valid = 1'b1; op = 3'd0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_start", 64'(start), 64'd0);
    check("abort_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b0; id_md = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) ok = 1'b0;
    end
    check("abort_no_commit", 64'(ok), 64'd1);

    // Operation offered on the very first edge after reset release.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; op_valid = 1'b1; op = 3'd0; rs = 32'd6; rt = 32'd7;
    #1;
    check("post_rst_start", 64'(start), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
    nb = 0;
    while (busy && nb < 100) begin nb++; @(negedge clk); end
    check("post_rst_busy_len", 64'(nb), 64'(MULT_N));
    check("post_rst_lo", 64'(lo), 64'd42);
    check("post_rst_hi", 64'(hi), 64'd0);

    // Randomized operations against the reference model.
    ref_hi = 32'd0;
    ref_lo = 32'd42;
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  r_op;
      logic [31:0] r_rs, r_rt;
      logic        r_id;
      r_op = 3'($urandom_range(0, 7));
      r_rs = $urandom;
      r_rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      r_id = 1'($urandom_range(0, 1));
      model(r_op, r_rs, r_rt, ref_hi, ref_lo, ref_n);
      do_op(r_op, r_rs, r_rt, r_id, ref_hi, ref_lo, ref_n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
